// File: rtl/irq_controller_pkg.sv
// Shared CPU constants for the external interrupt front-end: register map
// addresses and the cop0 external interrupt width.
package irq_controller_pkg;

    localparam logic [1:0] IRQ_ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] IRQ_ADDR_MODE    = 2'd1;
    localparam logic [1:0] IRQ_ADDR_PENDING = 2'd2;
    localparam logic [1:0] IRQ_ADDR_RAW     = 2'd3;

    localparam int IRQ_NUM = 7;

endpackage

// File: rtl/irq_sync.sv
// Per-bit multi-flop synchroniser for asynchronous inputs, cleared by the
// active-low asynchronous reset. SYNC_STAGES must be at least 2.
module irq_sync #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [SYNC_STAGES-1:0] stage_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= {stage_reg[SYNC_STAGES-2:0], d[gi]};
                end
            end

            assign q[gi] = stage_reg[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/irq_controller.sv
// External interrupt front-end: synchronises IRQ lines, latches edge/level
// pending state, masks with ENABLE and drives cop0 interrupts[6:0].
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int NUM_IRQ     = IRQ_NUM,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               sel,
    input  logic               we,
    input  logic [1:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic [NUM_IRQ-1:0] irq_out,
    output logic               irq_valid,
    output logic [2:0]         irq_id
);

    logic [NUM_IRQ-1:0] sync;
    logic [NUM_IRQ-1:0] prev_reg;
    logic [NUM_IRQ-1:0] enable_reg;
    logic [NUM_IRQ-1:0] mode_reg;
    logic [NUM_IRQ-1:0] pending_reg;
    logic [NUM_IRQ-1:0] pending_next;
    logic [NUM_IRQ-1:0] edge_det;
    logic [NUM_IRQ-1:0] w1c;
    logic [SYNC_STAGES:0] arm_reg;
    logic               armed;
    logic               wr_en;
    logic               unused_wdata;

    irq_sync #(
        .WIDTH       (NUM_IRQ),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (irq_in),
        .q     (sync)
    );

    assign wr_en        = sel & we;
    assign w1c          = (wr_en && addr == IRQ_ADDR_PENDING) ? wdata[NUM_IRQ-1:0] : '0;
    assign unused_wdata = ^wdata[31:NUM_IRQ];

    // Edges are ignored until the synchroniser has refilled after reset, so a
    // line that was already high only loads prev instead of faking an edge.
    assign armed = arm_reg[SYNC_STAGES];

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
            assign edge_det[gi]     = sync[gi] & ~prev_reg[gi] & armed;
            assign pending_next[gi] = mode_reg[gi]
                                    ? (edge_det[gi] | (pending_reg[gi] & ~w1c[gi]))
                                    : sync[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arm_reg     <= '0;
            prev_reg    <= '0;
            pending_reg <= '0;
            enable_reg  <= '0;
            mode_reg    <= '0;
        end else begin
            arm_reg     <= {arm_reg[SYNC_STAGES-1:0], 1'b1};
            prev_reg    <= sync;
            pending_reg <= pending_next;
            if (wr_en && addr == IRQ_ADDR_ENABLE) begin
                enable_reg <= wdata[NUM_IRQ-1:0];
            end
            if (wr_en && addr == IRQ_ADDR_MODE) begin
                mode_reg <= wdata[NUM_IRQ-1:0];
            end
        end
    end

    assign irq_out   = pending_reg & enable_reg;
    assign irq_valid = |irq_out;

    // Ascending scan so the highest-numbered active line wins.
    always_comb begin
        irq_id = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_out[i]) begin
                irq_id = 3'(i);
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            IRQ_ADDR_ENABLE:  rdata = {{(32-NUM_IRQ){1'b0}}, enable_reg};
            IRQ_ADDR_MODE:    rdata = {{(32-NUM_IRQ){1'b0}}, mode_reg};
            IRQ_ADDR_PENDING: rdata = {{(32-NUM_IRQ){1'b0}}, pending_reg};
            IRQ_ADDR_RAW:     rdata = {{(32-NUM_IRQ){1'b0}}, sync};
            default:          rdata = '0;
        endcase
    end

endmodule
